// File: rtl/ps2_device_tx.sv
// PS/2 device-to-host byte transmitter with host inhibit handling.
// Define PS2_DEVICE_TX_FIFO_EN for a 4-entry byte FIFO instead of one holding register.
module ps2_device_tx #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int PS2_CLK_HZ  = 12500,
    parameter int IDLE_US     = 50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_abort
);

    localparam int HALF     = CLK_FREQ_HZ / (2 * PS2_CLK_HZ);
    localparam int IDLE_CYC = CLK_FREQ_HZ / 1000000 * IDLE_US;
    localparam int CNT_MAX  = (HALF > IDLE_CYC) ? HALF : IDLE_CYC;
    localparam int CW       = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
    localparam logic [CW-1:0] IDLE_END = CW'(IDLE_CYC - 1);
    localparam logic [CW-1:0] HI_MASK  = CW'(3);

    typedef enum logic [2:0] {
        IDLE,
        BUS_WAIT,
        CLK_HI,
        CLK_LO,
        FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;

    logic [1:0] clk_sync, dat_sync;
    logic       clk_s, dat_s;

    logic       push, pop;
    logic       full, empty;
    logic [7:0] head;
    logic [10:0] frame;
    logic       bit_val;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_dat_in};
        end
    end

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];

    assign push     = tx_valid & tx_ready;
    assign pop      = tx_done;
    assign tx_ready = ~full;

`ifdef PS2_DEVICE_TX_FIFO_EN
    logic [7:0] mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] count;

    assign full  = (count == 3'd4);
    assign empty = (count == 3'd0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end
`else
    logic [7:0] hold_q;
    logic       hold_vld;

    assign full  = hold_vld;
    assign empty = ~hold_vld;
    assign head  = hold_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q   <= '0;
            hold_vld <= 1'b0;
        end else if (push) begin
            hold_q   <= tx_data;
            hold_vld <= 1'b1;
        end else if (pop) begin
            hold_vld <= 1'b0;
        end
    end
`endif

    // Bit 0 goes out first: start, data LSB first, odd parity, stop.
    assign frame   = {1'b1, ~^head, head, 1'b0};
    assign bit_val = frame[idx_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        ps2_clk_oe = 1'b0;
        ps2_dat_oe = 1'b0;
        tx_done    = 1'b0;
        tx_abort   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!empty) state_d = BUS_WAIT;
            end
            BUS_WAIT: begin
                if (clk_s && dat_s) begin
                    if (cnt_q == IDLE_END) begin
                        state_d = CLK_HI;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            CLK_HI: begin
                ps2_dat_oe = ~bit_val;
                // First cycles still see our own low clock through the synchronizer.
                if (cnt_q >= HI_MASK && !clk_s && idx_q <= 4'd9) begin
                    tx_abort = 1'b1;
                    state_d  = BUS_WAIT;
                    cnt_d    = '0;
                end else if (cnt_q == HALF_END) begin
                    state_d = CLK_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CLK_LO: begin
                ps2_clk_oe = 1'b1;
                ps2_dat_oe = ~bit_val;
                if (cnt_q == HALF_END) begin
                    cnt_d = '0;
                    if (idx_q == 4'd10) begin
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = CLK_HI;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FINISH: begin
                if (cnt_q == HALF_END) begin
                    tx_done = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    assign busy = ~empty | (state_q != IDLE);

endmodule

// File: tb/tb_ps2_device_tx.sv
// Directed bench for ps2_device_tx with a scaled clock (HALF=20, IDLE_CYC=100).
// Models the open-drain bus and a host that can inhibit or request-to-send.
module tb_ps2_device_tx;

    localparam int H   = 20;
    localparam int LIM = 3000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       busy, tx_done, tx_abort;
    logic       host_clk_low, host_dat_low;
    logic       ps2_clk_line, ps2_dat_line;

    int total = 0;
    int bad   = 0;

    int     done_cnt  = 0;
    int     abort_cnt = 0;
    longint done_t    = 0;

    logic [3:0]  nbits = '0;
    logic [10:0] cur   = '0;
    int          fall_total = 0;
    longint      first_t = 0, last_t = 0, prev_t = 0;
    logic [10:0] frames[$];

    assign ps2_clk_line = ~(ps2_clk_oe | host_clk_low);
    assign ps2_dat_line = ~(ps2_dat_oe | host_dat_low);

    always #5 clk = ~clk;

    ps2_device_tx #(
        .CLK_FREQ_HZ(2000000),
        .PS2_CLK_HZ (50000),
        .IDLE_US    (50)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .ps2_clk_in(ps2_clk_line),
        .ps2_dat_in(ps2_dat_line),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .busy      (busy),
        .tx_done   (tx_done),
        .tx_abort  (tx_abort)
    );

    always @(posedge clk) begin
        if (tx_done) begin
            done_cnt <= done_cnt + 1;
            done_t   <= $time;
        end
        if (tx_abort) abort_cnt <= abort_cnt + 1;
    end

    // Host-side receiver: data is sampled on device-driven clock falls.
    always @(negedge ps2_clk_line or posedge tx_abort or negedge reset_n) begin
        if (!reset_n || tx_abort) begin
            nbits = '0;
        end else if (ps2_clk_oe) begin
            if (nbits == 4'd0) first_t = $time;
            prev_t = last_t;
            last_t = $time;
            cur[nbits] = ps2_dat_line;
            fall_total++;
            if (nbits == 4'd10) begin
                frames.push_back(cur);
                nbits = '0;
            end else begin
                nbits = nbits + 4'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] nextf();
        if (frames.size() == 0) return 11'h7FF;
        return frames.pop_front();
    endfunction

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!tx_ready && n < LIM) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIM) chk("send_timeout", {31'd0, tx_ready}, 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < LIM) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIM) chk("done_timeout", done_cnt, target);
    endtask

    task automatic wait_falls(input int target);
        int n = 0;
        while (fall_total < target && n < LIM) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIM) chk("fall_timeout", fall_total, target);
    endtask

    task automatic wait_rise();
        int n = 0;
        while (!ps2_clk_line && n < LIM) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIM) chk("rise_timeout", {31'd0, ps2_clk_line}, 32'd1);
    endtask

    initial begin
        int d0, a0, f0, n, drv, len;
        reset_n      = 1'b0;
        tx_data      = '0;
        tx_valid     = 1'b0;
        host_clk_low = 1'b0;
        host_dat_low = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        chk("rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
        chk("rst_busy",   {31'd0, busy},       32'd0);
        chk("rst_ready",  {31'd0, tx_ready},   32'd1);
        chk("rst_done",   {31'd0, tx_done},    32'd0);
        chk("rst_abort",  {31'd0, tx_abort},   32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // 0x1C: bits 0,0,0,1,1,1,0,0,0,0,1
        d0 = done_cnt;
        send(8'h1C);
        chk("busy_1c", {31'd0, busy}, 32'd1);
        wait_done(d0 + 1);
        repeat (5) @(negedge clk);
        chk("frame_1c", {21'd0, nextf()}, {21'd0, 11'b10000111000});
        chk("done_1c", done_cnt, d0 + 1);
        chk("period", 32'((last_t - prev_t) / 10), 2 * H);
        len = int'((done_t - first_t) / 10);
        chk("frame_len", {31'd0, (len >= 22*H - 1 && len <= 22*H + 1)}, 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_ready", {31'd0, tx_ready}, 32'd1);

        // 0xFF then 0x00: both parity bits 1
        d0 = done_cnt;
        send(8'hFF);
        send(8'h00);
        wait_done(d0 + 2);
        repeat (5) @(negedge clk);
        chk("frame_ff", {21'd0, nextf()}, {21'd0, 11'b11111111110});
        chk("frame_00", {21'd0, nextf()}, {21'd0, 11'b11000000000});
        chk("done_ff00", done_cnt, d0 + 2);

        // Host request-to-send holds the device off
        d0 = done_cnt;
        f0 = fall_total;
        host_dat_low = 1'b1;
        send(8'h55);
        repeat (300) @(negedge clk);
        chk("rts_quiet", fall_total, f0);
        chk("rts_busy", {31'd0, busy}, 32'd1);
        host_dat_low = 1'b0;
        wait_done(d0 + 1);
        repeat (5) @(negedge clk);
        chk("frame_55", {21'd0, nextf()}, {21'd0, 11'b11010101010});

        // Host inhibit during CLK_HI of bit 3, then full resend
        d0 = done_cnt;
        a0 = abort_cnt;
        f0 = fall_total;
        send(8'h1C);
        wait_falls(f0 + 3);
        wait_rise();
        repeat (5) @(negedge clk);
        host_clk_low = 1'b1;
        n = 0;
        while (abort_cnt == a0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("abort_cnt", abort_cnt, a0 + 1);
        chk("abort_lat", {31'd0, n <= 4}, 32'd1);
        chk("abort_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        chk("abort_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
        drv = 0;
        repeat (60) begin
            @(negedge clk);
            drv |= int'(ps2_clk_oe | ps2_dat_oe);
        end
        chk("hold_quiet", drv, 0);
        host_clk_low = 1'b0;
        wait_done(d0 + 1);
        repeat (5) @(negedge clk);
        chk("frame_resend", {21'd0, nextf()}, {21'd0, 11'b10000111000});
        chk("resend_done", done_cnt, d0 + 1);

        // Clock pulled low in CLK_HI of the stop bit is ignored
        d0 = done_cnt;
        a0 = abort_cnt;
        f0 = fall_total;
        send(8'hAA);
        wait_falls(f0 + 10);
        wait_rise();
        repeat (5) @(negedge clk);
        host_clk_low = 1'b1;
        repeat (8) @(negedge clk);
        host_clk_low = 1'b0;
        wait_done(d0 + 1);
        repeat (5) @(negedge clk);
        chk("stop_no_abort", abort_cnt, a0);
        chk("frame_aa", {21'd0, nextf()}, {21'd0, 11'b11101010100});

        // Reset during bit 5 discards the byte
        d0 = done_cnt;
        f0 = fall_total;
        send(8'hA5);
        wait_falls(f0 + 6);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        chk("mid_rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
        chk("mid_rst_ready",  {31'd0, tx_ready},   32'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (150) @(negedge clk);
        chk("mid_rst_nodone", done_cnt, d0);
        chk("mid_rst_nofr", frames.size(), 0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        send(8'h3C);
        wait_done(d0 + 1);
        repeat (5) @(negedge clk);
        chk("frame_3c", {21'd0, nextf()}, {21'd0, 11'b11001111000});

`ifdef PS2_DEVICE_TX_FIFO_EN
        d0 = done_cnt;
        send(8'hF0);
        send(8'h1C);
        send(8'hAA);
        send(8'h55);
        chk("full_ready", {31'd0, tx_ready}, 32'd0);
        n = 0;
        while (!tx_ready && n < LIM) begin
            @(negedge clk);
            n++;
        end
        chk("ready_at_done", done_cnt, d0 + 1);
        wait_done(d0 + 4);
        repeat (5) @(negedge clk);
        chk("q_f0", {21'd0, nextf()}, {21'd0, 11'b11111100000});
        chk("q_1c", {21'd0, nextf()}, {21'd0, 11'b10000111000});
        chk("q_aa", {21'd0, nextf()}, {21'd0, 11'b11101010100});
        chk("q_55", {21'd0, nextf()}, {21'd0, 11'b11010101010});
`else
        d0 = done_cnt;
        send(8'hF0);
        chk("held_ready", {31'd0, tx_ready}, 32'd0);
        n = 0;
        while (!tx_ready && n < LIM) begin
            @(negedge clk);
            n++;
        end
        chk("ready_at_done", done_cnt, d0 + 1);
        send(8'h1C);
        wait_done(d0 + 2);
        repeat (5) @(negedge clk);
        chk("q_f0", {21'd0, nextf()}, {21'd0, 11'b11111100000});
        chk("q_1c", {21'd0, nextf()}, {21'd0, 11'b10000111000});
`endif
        chk("no_extra_frames", frames.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
